uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have port CLK  input  1: single system clock; all state changes on rising edge.
REQ-003 SHALL have port RST  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH: parallel byte to transmit.
REQ-005 SHALL have port Data_Valid  input  1: request to send P_DATA; single-cycle or held.
REQ-006 SHALL have port PAR_EN  input  1: 1 = parity bit inserted in frame.
REQ-007 SHALL have port PAR_TYP  input  1: 0 = even parity, 1 = odd parity.
REQ-008 SHALL have port Mux_Sel  output  2: select for the 4:1 TX line mux: 00 start, 01 stop/idle, 10 serial data, 11 parity.
REQ-009 SHALL have port Ser_Data  output  1: current data bit, routed to the mux "10" input.
REQ-010 SHALL have port Par_Bit  output  1: frame parity bit, routed to the mux "11" input.
REQ-011 SHALL have port Busy  output  1: high while a frame is in progress.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, START, DATA, PARITY, STOP; Mux_Sel and Busy decoded from the state register only.
REQ-013 SHALL drive Mux_Sel = 01 and Busy = 0 in IDLE; Mux_Sel = 00/10/11/01 and Busy = 1 in START/DATA/PARITY/STOP respectively.
REQ-014 SHALL accept a request when Data_Valid = 1 in IDLE or STOP; acceptance latches P_DATA, PAR_EN, PAR_TYP; next state START (1-cycle latency).
REQ-015 SHALL ignore Data_Valid in START, DATA and PARITY; no queuing, no effect on the frame in progress.
REQ-016 SHALL hold START exactly 1 cycle, then enter DATA.
REQ-017 SHALL hold DATA exactly DATA_WIDTH cycles, shifting LSB first; Ser_Data = latched bit[i] in the i-th DATA cycle (i = 0..DATA_WIDTH-1).
REQ-018 SHALL use a bit counter of width clog2(DATA_WIDTH), cleared on entering DATA, incremented each DATA cycle; leave DATA when counter = DATA_WIDTH-1.
REQ-019 SHALL go DATA -> PARITY when latched PAR_EN = 1, else DATA -> STOP.
REQ-020 SHALL hold PARITY exactly 1 cycle, then STOP.
REQ-021 SHALL compute Par_Bit = XOR-reduce(latched data) for even, its inverse for odd; stable from START to end of STOP.
REQ-022 SHALL hold STOP exactly 1 cycle; then START if a request was accepted in that cycle (Busy stays 1, back-to-back), else IDLE.
REQ-023 SHALL give frame length 1 + DATA_WIDTH + PAR_EN + 1 cycles (11 with parity, 10 without, at DATA_WIDTH = 8).
REQ-024 SHALL hold Ser_Data at 0 outside DATA; input changes mid-frame SHALL NOT alter the frame.

Reset
REQ-025 SHALL, on RST low, immediately force IDLE: Mux_Sel = 01, Busy = 0, Ser_Data = 0, Par_Bit = 0, counter = 0, data/config latches = 0.
REQ-026 SHALL abort a mid-frame reset without completion; the first request after RST release is handled as from IDLE.

Structure
REQ-027 SHALL take state encoding and Mux_Sel constants (SEL_START = 00, SEL_STOP = 01, SEL_DATA = 10, SEL_PAR = 11) from shared package uart_pkg, also used by the TX top.
REQ-028 SHALL place the shift register and bit counter in one sub-module, uart_serializer (load, shift-enable, done outputs); FSM and parity logic stay in uart_tx_ctrl.

Verification
REQ-029 SHALL cover: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, 1-cycle Data_Valid -> Mux_Sel 00, 10x8, 11, 01; Ser_Data 1,0,1,0,0,1,0,1; Par_Bit = 0; Busy high 11 cycles.
REQ-030 SHALL cover: 0xA5, PAR_EN = 1, PAR_TYP = 1 -> Par_Bit = 1; 0x3C, PAR_EN = 0 -> no 11 select, Busy high 10 cycles, Ser_Data 0,0,1,1,1,1,0,0.
REQ-031 SHALL cover: Data_Valid held high continuously with 0x55 then 0xAA -> two frames back-to-back, Busy never drops, START immediately follows STOP.
REQ-032 SHALL cover: Data_Valid pulsed in DATA cycle 3 with new P_DATA -> ignored; current frame unchanged, IDLE after STOP.
REQ-033 SHALL cover: RST asserted in DATA cycle 5 -> same-instant Mux_Sel = 01, Busy = 0; after release, 0x0F frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and TX line mux selects.
// Used by the TX controller and by the TX top that owns the line mux.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    // Idle and stop both drive the line high, so they share SEL_STOP.
    function automatic logic [1:0] state_to_sel(tx_state_e state);
        logic [1:0] sel;
        case (state)
            StStart:  sel = SEL_START;
            StData:   sel = SEL_DATA;
            StParity: sel = SEL_PAR;
            default:  sel = SEL_STOP;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Request/frame-control bundle between a byte source, the TX controller and the TX line mux.
// The master drives the request side; the slave (controller) drives the mux controls.
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            Mux_Sel;
    logic                  Ser_Data;
    logic                  Par_Bit;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  Mux_Sel,
        input  Ser_Data,
        input  Par_Bit,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output Mux_Sel,
        output Ser_Data,
        output Par_Bit,
        output Busy
    );

endinterface

// File: rtl/uart_serializer.sv
// LSB-first shift register with bit counter for the UART transmitter.
// load captures a new word and clears the count; each shift_en cycle advances one bit.
module uart_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_bit,
    output logic                  done
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CntW-1:0]       cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= load_data;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign ser_bit = shift_q[0];
    // Asserted during the last data bit so the FSM leaves DATA after exactly DATA_WIDTH cycles.
    assign done    = (cnt_q == CntW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: Moore FSM sequencing start, data, optional parity and stop.
// Requests are taken only in IDLE or STOP, so a STOP-cycle request chains frames back-to-back.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  accept;
    logic                  ser_bit;
    logic                  ser_done;

    assign accept = bus.Data_Valid && ((state_q == StIdle) || (state_q == StStop));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            if (accept) begin
                data_q    <= bus.P_DATA;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
            end
            case (state_q)
                StIdle:   if (accept) state_q <= StStart;
                StStart:  state_q <= StData;
                StData:   if (ser_done) state_q <= par_en_q ? StParity : StStop;
                StParity: state_q <= StStop;
                StStop:   state_q <= accept ? StStart : StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    uart_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (accept),
        .shift_en  (state_q == StData),
        .load_data (bus.P_DATA),
        .ser_bit   (ser_bit),
        .done      (ser_done)
    );

    assign bus.Mux_Sel  = state_to_sel(state_q);
    assign bus.Busy     = (state_q != StIdle);
    assign bus.Ser_Data = (state_q == StData) && ser_bit;
    // Parity comes from the latched word, so it holds for the whole frame.
    assign bus.Par_Bit  = (^data_q) ^ par_typ_q;

endmodule
